// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pkg;

   // Config fields are carried at their widest supported width; channels
   // zero-extend narrower inputs so the struct does not depend on parameters.
   localparam int CFG_PERIOD_W = 32;
   localparam int CFG_DUTY_W   = 16;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_STEADY  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   typedef struct packed {
      mode_t                   mode;
      logic [CFG_PERIOD_W-1:0] period;
      logic [CFG_DUTY_W-1:0]   duty;
   } cfg_t;

   // PWM compare: full scale is forced on so maximum brightness has no gap.
   function automatic logic pwm_on(input logic [31:0] cnt,
                                   input logic [31:0] x,
                                   input logic [31:0] max_val);
      return (x == max_val) ? 1'b1 : (cnt < x);
   endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: config registers, blink/breathe timing and raw PWM output.
module led_chan
   import led_pkg::*;
#(
   parameter int PWM_W      = 8,
   parameter int DIV_W      = 27,
   parameter int RST_MODE   = 2,
   parameter int RST_PERIOD = 100000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PWM_W-1:0] pwm_cnt,
   input  logic             commit,
   input  cfg_t             new_cfg,
   output logic             raw
);

   localparam logic [31:0]      PWM_MAX   = 32'((1 << PWM_W) - 1);
   localparam logic [PWM_W-1:0] LEVEL_MAX = '1;
   localparam cfg_t RST_CFG = '{mode:   mode_t'(2'(RST_MODE)),
                                period: 32'(RST_PERIOD),
                                duty:   16'(PWM_MAX)};

   cfg_t             cfg;
   logic [DIV_W-1:0] cnt;
   logic             phase;
   logic [PWM_W-1:0] level;
   logic             dir_up;
   logic [31:0]      p_eff;
   logic             wrap;
   logic [PWM_W-1:0] next_level;

   // Interval timing: a zero period behaves as one cycle so the counter always wraps.
   always_comb begin
      p_eff      = (cfg.period == '0) ? 32'd1 : cfg.period;
      wrap       = (32'(cnt) == (p_eff - 32'd1));
      next_level = dir_up ? (level + PWM_W'(1)) : (level - PWM_W'(1));
   end

   // Channel state: a commit reloads config and restarts timing, overriding any wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg    <= RST_CFG;
         cnt    <= '0;
         phase  <= 1'b0;
         level  <= '0;
         dir_up <= 1'b1;
      end else if (commit) begin
         cfg    <= new_cfg;
         cnt    <= '0;
         phase  <= 1'b0;
         level  <= '0;
         dir_up <= 1'b1;
      end else if (wrap) begin
         cnt   <= '0;
         phase <= ~phase;
         if (cfg.mode == MODE_BREATHE) begin
            level <= next_level;
            if (dir_up && (next_level == LEVEL_MAX)) begin
               dir_up <= 1'b0;
            end else if (!dir_up && (next_level == '0)) begin
               dir_up <= 1'b1;
            end
         end
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Raw drive per mode; the top level registers it onto the pin.
   always_comb begin
      raw = 1'b0;
      case (cfg.mode)
         MODE_OFF:     raw = 1'b0;
         MODE_STEADY:  raw = pwm_on(32'(pwm_cnt), 32'(cfg.duty), PWM_MAX);
         MODE_BLINK:   raw = phase & pwm_on(32'(pwm_cnt), 32'(cfg.duty), PWM_MAX);
         MODE_BREATHE: raw = pwm_on(32'(pwm_cnt), 32'(level), PWM_MAX);
         default:      raw = 1'b0;
      endcase
   end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared PWM counter, config shadow with
// frame-boundary commit, and registered LED outputs.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int  NUM_CH     = 3,
   parameter int  DIV_W      = 27,
   parameter int  PWM_W      = 8,
   parameter int  RST_MODE   = 2,
   parameter int  RST_PERIOD = 100000000,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [DIV_W-1:0]  cfg_period,
   input  logic [PWM_W-1:0]  cfg_duty,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] led
);

   localparam logic [PWM_W-1:0] PWM_MAX  = '1;
   localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

   logic [PWM_W-1:0]  pwm_cnt;
   logic              pend;
   cfg_t              shadow;
   logic [CH_W-1:0]   shadow_ch;
   logic [NUM_CH-1:0] raw;
   logic              accept;
   logic              ch_ok;
   logic              commit;

   assign cfg_ready = ~pend;
   assign accept    = cfg_valid & ~pend;
   assign ch_ok     = ({1'b0, cfg_ch} < NUM_CH_V);
   assign commit    = pend & (pwm_cnt == PWM_MAX);

   // Free-running PWM counter; one frame spans its full range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   // Request capture: valid targets wait in the shadow until the frame ends, bad targets pulse cfg_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         cfg_err   <= 1'b0;
         shadow_ch <= '0;
         shadow    <= '{mode: MODE_OFF, period: '0, duty: '0};
      end else begin
         cfg_err <= accept & ~ch_ok;
         if (commit) begin
            pend <= 1'b0;
         end else if (accept && ch_ok) begin
            pend      <= 1'b1;
            shadow_ch <= cfg_ch;
            shadow    <= '{mode:   mode_t'(cfg_mode),
                           period: 32'(cfg_period),
                           duty:   16'(cfg_duty)};
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      led_chan #(
         .PWM_W      (PWM_W),
         .DIV_W      (DIV_W),
         .RST_MODE   (RST_MODE),
         .RST_PERIOD (RST_PERIOD)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .pwm_cnt (pwm_cnt),
         .commit  (commit & (shadow_ch == CH_W'(i))),
         .new_cfg (shadow),
         .raw     (raw[i])
      );
   end

   // Output register keeps the pins free of decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= raw;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen with a cycle-level behavioural model.
module tb_led_pattern_gen;

   localparam int NUM_CH = 3;
   localparam int PWM_W  = 4;
   localparam int DIV_W  = 8;
   localparam int MAXV   = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [1:0]        cfg_mode;
   logic [DIV_W-1:0]  cfg_period;
   logic [PWM_W-1:0]  cfg_duty;
   logic              cfg_err;
   logic [NUM_CH-1:0] led;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [2:0] led;
      logic       ready;
      logic       err;
   } exp_t;
   exp_t sbq[$];

   int         c_mode[3], c_per[3], c_duty[3], c_cnt[3], c_lvl[3];
   bit         c_ph[3], c_up[3];
   int         m_pwm, sh_ch, sh_mode, sh_per, sh_duty;
   bit         m_pend, m_err;
   logic [2:0] m_led;

   led_pattern_gen #(
      .NUM_CH     (NUM_CH),
      .DIV_W      (DIV_W),
      .PWM_W      (PWM_W),
      .RST_MODE   (2),
      .RST_PERIOD (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .cfg_err    (cfg_err),
      .led        (led)
   );

   always #5 clk = ~clk;

   // Hard stop in case the run never reaches its summary.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pwmBit(input int x);
      return (x == MAXV) || (m_pwm < x);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         c_mode[i] = 2; c_per[i] = 5; c_duty[i] = MAXV;
         c_cnt[i] = 0; c_ph[i] = 0; c_lvl[i] = 0; c_up[i] = 1;
      end
      m_pwm = 0; m_pend = 0; m_err = 0; m_led = '0;
      sh_ch = 0; sh_mode = 0; sh_per = 0; sh_duty = 0;
   endtask

   task automatic modelStep();
      logic [2:0] nled;
      bit acc, com;
      int p;
      for (int i = 0; i < 3; i++) begin
         case (c_mode[i])
            1:       nled[i] = pwmBit(c_duty[i]);
            2:       nled[i] = c_ph[i] && pwmBit(c_duty[i]);
            3:       nled[i] = pwmBit(c_lvl[i]);
            default: nled[i] = 1'b0;
         endcase
      end
      acc = cfg_valid && !m_pend;
      com = m_pend && (m_pwm == MAXV);
      for (int i = 0; i < 3; i++) begin
         if (com && sh_ch == i) begin
            c_mode[i] = sh_mode; c_per[i] = sh_per; c_duty[i] = sh_duty;
            c_cnt[i] = 0; c_ph[i] = 0; c_lvl[i] = 0; c_up[i] = 1;
         end else begin
            p = (c_per[i] == 0) ? 1 : c_per[i];
            if (c_cnt[i] == p - 1) begin
               c_cnt[i] = 0;
               c_ph[i]  = !c_ph[i];
               if (c_mode[i] == 3) begin
                  if (c_up[i]) begin
                     c_lvl[i]++;
                     if (c_lvl[i] == MAXV) c_up[i] = 0;
                  end else begin
                     c_lvl[i]--;
                     if (c_lvl[i] == 0) c_up[i] = 1;
                  end
               end
            end else begin
               c_cnt[i]++;
            end
         end
      end
      m_err = acc && (int'(cfg_ch) >= NUM_CH);
      if (com) begin
         m_pend = 0;
      end else if (acc && int'(cfg_ch) < NUM_CH) begin
         m_pend = 1; sh_ch = int'(cfg_ch); sh_mode = int'(cfg_mode);
         sh_per = int'(cfg_period); sh_duty = int'(cfg_duty);
      end
      m_pwm = (m_pwm + 1) % (MAXV + 1);
      m_led = nled;
      sbq.push_back({m_led, !m_pend, m_err});
   endtask

   // One clock: drive inputs, record expectations, then compare after the edge.
   task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [1:0] mode,
                                input logic [DIV_W-1:0] per, input logic [PWM_W-1:0] duty);
      exp_t e;
      @(negedge clk);
      cfg_valid = v; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
      modelStep();
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      checkOutput("led", 32'(led), 32'(e.led));
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(e.ready));
      checkOutput("cfg_err", 32'(cfg_err), 32'(e.err));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 2'd0, '0, '0);
   endtask

   task automatic cfgWrite(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [DIV_W-1:0] per, input logic [PWM_W-1:0] duty,
                           output int tries);
      bit acc;
      tries = 0;
      acc = 0;
      while (!acc && tries < 40) begin
         acc = !m_pend;
         applyStimulus(1'b1, ch, mode, per, duty);
         tries++;
      end
      if (!acc) checkOutput("write_timeout", 32'd1, 32'd0);
   endtask

   task automatic waitCommit();
      int k = 0;
      while (m_pend && k < 40) begin
         idle(1);
         k++;
      end
      if (m_pend) checkOutput("commit_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int tries, ones, toggles, diffs;
      logic prev;
      cfg_valid = 0; cfg_ch = 0; cfg_mode = 0; cfg_period = '0; cfg_duty = '0;
      rst_n = 0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_led", 32'(led), 32'd0);
      checkOutput("rst_ready", 32'(cfg_ready), 32'd1);
      checkOutput("rst_err", 32'(cfg_err), 32'd0);
      #1 rst_n = 1;

      $display("[TB] default blink on all channels");
      idle(30);

      $display("[TB] ch1 steady duty 4");
      cfgWrite(2'd1, 2'd1, 8'd0, 4'd4, tries);
      waitCommit();
      idle(3);
      ones = 0;
      for (int k = 0; k < 16; k++) begin
         idle(1);
         ones += int'(led[1]);
      end
      checkOutput("steady_ones", 32'(ones), 32'd4);

      $display("[TB] ch2 blink period 0");
      cfgWrite(2'd2, 2'd2, 8'd0, 4'd15, tries);
      waitCommit();
      idle(1);
      prev = led[2];
      toggles = 0;
      for (int k = 0; k < 10; k++) begin
         idle(1);
         if (led[2] !== prev) toggles++;
         prev = led[2];
      end
      checkOutput("fast_toggles", 32'(toggles), 32'd10);
      cfgWrite(2'd2, 2'd2, 8'd3, 4'd0, tries);
      waitCommit();
      idle(2);
      ones = 0;
      for (int k = 0; k < 20; k++) begin
         idle(1);
         ones += int'(led[2]);
      end
      checkOutput("duty0_ones", 32'(ones), 32'd0);

      $display("[TB] ch0 breathe period 2");
      cfgWrite(2'd0, 2'd3, 8'd2, 4'd0, tries);
      waitCommit();
      idle(140);

      $display("[TB] bad channel and back-to-back requests");
      applyStimulus(1'b1, 2'd3, 2'd1, 8'd7, 4'd3);
      checkOutput("err_pulse", 32'(cfg_err), 32'd1);
      checkOutput("err_ready", 32'(cfg_ready), 32'd1);
      idle(1);
      checkOutput("err_single", 32'(cfg_err), 32'd0);
      cfgWrite(2'd2, 2'd1, 8'd0, 4'd8, tries);
      cfgWrite(2'd1, 2'd0, 8'd0, 4'd0, tries);
      checkOutput("held_off", 32'(tries > 1), 32'd1);
      waitCommit();
      idle(20);

      $display("[TB] reset with update pending");
      begin
         int k = 0;
         while (m_pwm != 3 && k < 20) begin
            idle(1);
            k++;
         end
      end
      cfgWrite(2'd1, 2'd3, 8'd1, 4'd0, tries);
      idle(2);
      checkOutput("pend_before_rst", 32'(cfg_ready), 32'd0);
      #2 rst_n = 0;
      #1;
      checkOutput("rst_mid_led", 32'(led), 32'd0);
      checkOutput("rst_mid_ready", 32'(cfg_ready), 32'd1);
      modelReset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      diffs = 0;
      for (int k = 0; k < 40; k++) begin
         idle(1);
         if (led[1] !== led[0]) diffs++;
      end
      checkOutput("pending_dropped", 32'(diffs), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
